// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard scoreboard: instruction kinds,
// the shadow-pipeline entry and the counter saturation value.
package hazard_pkg;

    typedef enum logic [1:0] {
        KIND_ALU  = 2'd0,
        KIND_LOAD = 2'd1,
        KIND_LINK = 2'd2,
        KIND_NONE = 2'd3
    } kind_e;

    // Entry rd is stored at a fixed width; narrower register files zero-extend.
    localparam int RD_AW_MAX = 8;

    typedef struct packed {
        logic                 valid;
        logic [RD_AW_MAX-1:0] rd;
        logic                 wren;
        kind_e                kind;
    } shadow_entry_t;

    localparam logic [63:0] CNT_SAT_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority matcher for one source operand: the youngest in-flight writer
// of the register selects the forwarding source.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_AW     = 5,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  shadow_entry_t [NUM_STAGES-1:0] entries,
    input  logic [REG_AW-1:0]              rs,
    input  logic                           rs_used,
    output logic [SEL_W-1:0]               sel,
    output logic                           link,
    output logic                           load_hit
);

    logic [NUM_STAGES-1:0] match_s;
    logic [RD_AW_MAX-1:0]  rs_ext_s;

    assign rs_ext_s = RD_AW_MAX'(rs);

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_match
        assign match_s[g] = entries[g].valid & entries[g].wren & rs_used &
                            (entries[g].rd != {RD_AW_MAX{1'b0}}) &
                            (entries[g].rd == rs_ext_s);
    end

    // Walk oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        sel      = {SEL_W{1'b0}};
        link     = 1'b0;
        load_hit = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            sel      = match_s[k] ? SEL_W'(k + 1) : sel;
            link     = match_s[k] ? (entries[k].kind == KIND_LINK) : link;
            load_hit = match_s[k] ? ((entries[k].kind == KIND_LOAD) && ((k + 1) <= LOAD_LAT))
                                  : load_hit;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Data-hazard and forwarding unit beside ID: shadow pipeline of destination
// registers, per-operand forward selects, load-use stall and event counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_AW     = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 32,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_rd_wren_i,
    input  logic [1:0]        id_kind_i,
    input  logic              flush_i,
    input  logic              mem_busy_i,
    output logic              stall_o,
    output logic              bubble_o,
    output logic [SEL_W-1:0]  fwd_rs1_o,
    output logic [SEL_W-1:0]  fwd_rs2_o,
    output logic              link_rs1_o,
    output logic              link_rs2_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_SAT_ALL);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    shadow_entry_t [NUM_STAGES-1:0] shadow_r;
    shadow_entry_t                  entry_in_s;
    logic [CNT_W-1:0]               stall_cnt_r;
    logic [CNT_W-1:0]               flush_cnt_r;
    logic [SEL_W-1:0]               sel1_s;
    logic [SEL_W-1:0]               sel2_s;
    logic                           load1_s;
    logic                           load2_s;
    logic                           hazard_s;

    hazard_fwd_sel #(
        .NUM_STAGES (NUM_STAGES),
        .REG_AW     (REG_AW),
        .LOAD_LAT   (LOAD_LAT),
        .SEL_W      (SEL_W)
    ) u_sel_rs1 (
        .entries  (shadow_r),
        .rs       (id_rs1_i),
        .rs_used  (id_rs1_used_i),
        .sel      (sel1_s),
        .link     (link_rs1_o),
        .load_hit (load1_s)
    );

    hazard_fwd_sel #(
        .NUM_STAGES (NUM_STAGES),
        .REG_AW     (REG_AW),
        .LOAD_LAT   (LOAD_LAT),
        .SEL_W      (SEL_W)
    ) u_sel_rs2 (
        .entries  (shadow_r),
        .rs       (id_rs2_i),
        .rs_used  (id_rs2_used_i),
        .sel      (sel2_s),
        .link     (link_rs2_o),
        .load_hit (load2_s)
    );

    // Hazard detection, pipe control and the entry that would enter stage 1.
    always_comb begin
        hazard_s         = id_valid_i & (load1_s | load2_s);
        stall_o          = hazard_s | mem_busy_i;
        bubble_o         = (hazard_s | flush_i | ~id_valid_i) & ~mem_busy_i;
        fwd_rs1_o        = hazard_s ? {SEL_W{1'b0}} : sel1_s;
        fwd_rs2_o        = hazard_s ? {SEL_W{1'b0}} : sel2_s;
        entry_in_s.valid = id_valid_i & ~hazard_s & ~flush_i;
        entry_in_s.rd    = RD_AW_MAX'(id_rd_i);
        entry_in_s.wren  = id_rd_wren_i;
        entry_in_s.kind  = kind_e'(id_kind_i);
    end

    // Shadow pipeline advance; memory wait freezes every stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_r <= '0;
        end else if (mem_busy_i) begin
            shadow_r <= shadow_r;
        end else begin
            for (int k = NUM_STAGES - 1; k >= 1; k--) begin
                shadow_r[k] <= shadow_r[k-1];
            end
            shadow_r[0] <= entry_in_s;
        end
    end

    // Saturating stall/flush event counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (hazard_s && !mem_busy_i && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_i && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_r;
    assign flush_cnt_o = flush_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;

    localparam logic [1:0] K_ALU  = 2'd0;
    localparam logic [1:0] K_LOAD = 2'd1;
    localparam logic [1:0] K_LINK = 2'd2;
    localparam logic [1:0] K_NONE = 2'd3;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_rs1_used_i, id_rs2_used_i, id_rd_wren_i;
    logic [1:0]  id_kind_i;
    logic        flush_i, mem_busy_i;
    logic        stall_o, bubble_o, link_rs1_o, link_rs2_o;
    logic [1:0]  fwd_rs1_o, fwd_rs2_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .id_rd_i       (id_rd_i),
        .id_rd_wren_i  (id_rd_wren_i),
        .id_kind_i     (id_kind_i),
        .flush_i       (flush_i),
        .mem_busy_i    (mem_busy_i),
        .stall_o       (stall_o),
        .bubble_o      (bubble_o),
        .fwd_rs1_o     (fwd_rs1_o),
        .fwd_rs2_o     (fwd_rs2_o),
        .link_rs1_o    (link_rs1_o),
        .link_rs2_o    (link_rs2_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic we, input logic [1:0] kind);
        id_valid_i    = v;
        id_rs1_i      = rs1;
        id_rs1_used_i = u1;
        id_rs2_i      = rs2;
        id_rs2_used_i = u2;
        id_rd_i       = rd;
        id_rd_wren_i  = we;
        id_kind_i     = kind;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, K_NONE);
        repeat (3) step();
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; mem_busy_i = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, K_NONE);
        repeat (2) step();
        rst_i = 1'b0;

        // Reset state with a harmless valid instruction in ID
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, K_NONE);
        chk("rst_stall", stall_o, 0);
        chk("rst_bubble", bubble_o, 0);
        chk("rst_fwd1", fwd_rs1_o, 0);
        chk("rst_fwd2", fwd_rs2_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        chk("rst_flush_cnt", flush_cnt_o, 0);
        drain();

        // ALU x5 followed by consumers one and two cycles later
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, K_ALU);
        step();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, K_ALU);
        chk("alu_fwd1_d1", fwd_rs1_o, 1);
        chk("alu_stall_d1", stall_o, 0);
        step();
        chk("alu_fwd1_d2", fwd_rs1_o, 2);
        chk("alu_link_d2", link_rs1_o, 0);
        drain();

        // Load-use: one stall cycle, then forwarding from stage 2
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, K_LOAD);
        step();
        set_id(1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, K_ALU);
        chk("lu_stall", stall_o, 1);
        chk("lu_bubble", bubble_o, 1);
        chk("lu_fwd2_forced", fwd_rs2_o, 0);
        step();
        chk("lu_stall_after", stall_o, 0);
        chk("lu_bubble_after", bubble_o, 0);
        chk("lu_fwd2_after", fwd_rs2_o, 2);
        chk("lu_fwd1_x0", fwd_rs1_o, 0);
        chk("lu_stall_cnt", stall_cnt_o, 1);
        step();
        drain();

        // JAL x1 then JALR x1 (rd=x0), then consumer of x0 and x1
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, K_LINK);
        step();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, K_LINK);
        chk("link_fwd1", fwd_rs1_o, 1);
        chk("link_link1", link_rs1_o, 1);
        step();
        set_id(1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 5'd9, 1'b1, K_ALU);
        chk("x0_fwd1", fwd_rs1_o, 0);
        chk("x0_link1", link_rs1_o, 0);
        chk("link_fwd2_s2", fwd_rs2_o, 2);
        chk("link_link2_s2", link_rs2_o, 1);
        drain();

        // Two writers of x3: youngest wins; unused rs2 never forwards
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, K_ALU);
        step();
        set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, K_ALU);
        step();
        set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd4, 1'b1, K_ALU);
        chk("yw_fwd1", fwd_rs1_o, 1);
        chk("yw_fwd2_unused", fwd_rs2_o, 0);
        drain();

        // Memory wait during a load hazard freezes state and counters
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, K_LOAD);
        step();
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, K_ALU);
        mem_busy_i = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            chk("busy_stall", stall_o, 1);
            chk("busy_bubble", bubble_o, 0);
            chk("busy_fwd1", fwd_rs1_o, 0);
            step();
            chk("busy_stall_cnt", stall_cnt_o, 1);
        end
        mem_busy_i = 1'b0; #1;
        chk("rel_stall", stall_o, 1);
        chk("rel_bubble", bubble_o, 1);
        step();
        chk("rel_stall_cnt", stall_cnt_o, 2);
        chk("rel_fwd1", fwd_rs1_o, 2);
        chk("rel_stall_done", stall_o, 0);
        drain();

        // Flush together with a hazard: consumer is not entered
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, K_LOAD);
        step();
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, K_ALU);
        flush_i = 1'b1; #1;
        chk("fl_stall", stall_o, 1);
        chk("fl_bubble", bubble_o, 1);
        step();
        flush_i = 1'b0;
        set_id(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, K_ALU);
        chk("fl_flush_cnt", flush_cnt_o, 1);
        chk("fl_stall_cnt", stall_cnt_o, 3);
        chk("fl_fwd1", fwd_rs1_o, 2);
        chk("fl_fwd2_killed", fwd_rs2_o, 0);
        drain();

        // Reset asserted mid-stall
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, K_LOAD);
        step();
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, K_ALU);
        chk("rs_stall_before", stall_o, 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0; #1;
        chk("rs_stall", stall_o, 0);
        chk("rs_bubble", bubble_o, 0);
        chk("rs_fwd1", fwd_rs1_o, 0);
        chk("rs_link1", link_rs1_o, 0);
        chk("rs_stall_cnt", stall_cnt_o, 0);
        chk("rs_flush_cnt", flush_cnt_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised data-hazard and forwarding unit for the branch-predicting RISC-V pipeline, sitting beside the ID stage. It keeps a shadow pipeline of in-flight destination registers for `NUM_STAGES` downstream stages and selects per-operand forwarding sources. It generates load-use stalls for a configurable load latency, freezes on data-memory wait and discards killed instructions on branch-mispredict flush. It also keeps stall/flush event counters.

## Interface
- `NUM_STAGES`, 3: number of tracked stages after ID (stage 1 = EX … stage N = last before WB).
- `REG_AW`, 5: register-address width.
- `LOAD_LAT`, 1: a LOAD in stage k is forwardable only when k > `LOAD_LAT`; legal range 0..`NUM_STAGES`-1.
- `CNT_W`, 32: event-counter width.
- `SEL_W`, derived as $clog2(`NUM_STAGES`+1): forwarding-select width.
- `clk_i` in 1: clock. Reset is synchronous and active-high; one clock only.
- `rst_i` in 1: synchronous active-high reset.
- `id_valid_i` in 1: ID holds a valid instruction.
- `id_rs1_i`, `id_rs2_i` in `REG_AW`: source registers.
- `id_rs1_used_i`, `id_rs2_used_i` in 1: operand actually read (low for LUI/AUIPC/JAL, rs2 for I/L/JALR).
- `id_rd_i` in `REG_AW`: destination register.
- `id_rd_wren_i` in 1: destination written.
- `id_kind_i` in 2: `KIND_ALU`, `KIND_LOAD`, `KIND_LINK` (JAL/JALR, result is PC+4), `KIND_NONE`.
- `flush_i` in 1: mispredict resolved in EX; the ID instruction is killed.
- `mem_busy_i` in 1: data memory not ready; whole pipe holds.
- `stall_o` out 1: hold PC and IF/ID.
- `bubble_o` out 1: insert NOP into EX.
- `fwd_rs1_o`, `fwd_rs2_o` out `SEL_W`: 0 = register file, k = stage k result.
- `link_rs1_o`, `link_rs2_o` out 1: selected source is a LINK; use that stage's PC+4.
- `stall_cnt_o`, `flush_cnt_o` out `CNT_W`: saturating event counters.

## Operation
- Shadow entry per stage: valid, rd, wren, kind. Entry k "matches" operand r when valid, wren, rd≠0, rd==r and r's used bit is high.
- Per operand: the youngest matching stage (smallest k) wins. `fwd` = k, `link` = (kind==LINK). No match, or rs==x0 → `fwd`=0, `link`=0.
- Load-use: the winning match is a LOAD with k ≤ `LOAD_LAT` and `id_valid_i` is high → hazard. On hazard, `fwd` is forced to 0.
- `stall_o` = hazard | `mem_busy_i`. `bubble_o` = (hazard | `flush_i` | !`id_valid_i`) & !`mem_busy_i`.
- Register update priority: `rst_i` > `mem_busy_i` (all entries hold) > normal advance.
- Normal advance: entry k+1 ← entry k. Entry 1 ← ID fields when `id_valid_i` & !hazard & !`flush_i`; otherwise entry 1 ← invalid.
- `stall_cnt_o` increments on each hazard cycle with !`mem_busy_i`. `flush_cnt_o` increments on each `flush_i` cycle. Both saturate at all-ones.
- Simultaneous hazard and flush: the flush wins for entry 1 (bubble inserted). The stall counter still increments. `stall_o` is asserted.

## Timing
- Forward selects, `stall_o` and `bubble_o` are combinational from shadow state and ID inputs, valid in the same cycle.
- Shadow state and counters update on `posedge clk_i`.
- Load-use penalty: `LOAD_LAT`+1−d stall cycles for a consumer d cycles behind the load (d ≥ 1). Example: `LOAD_LAT`=1, back-to-back → 1 stall cycle.
- Reset: all entries invalid, all outputs 0, counters 0. Reset asserted mid-stall drops the stall on the next cycle.
- `mem_busy_i` for n cycles: state frozen; forwarding outputs stay stable if ID inputs are stable.

## Structure
- `hazard_pkg`: `kind_e` enum, shadow-entry struct (valid, rd, wren, kind), counter saturation constant.
- One sub-module `hazard_fwd_sel`: priority matcher over `NUM_STAGES` entries for one operand, producing sel/link/load_hit. Instantiated twice, for rs1 and rs2.

## Test plan
- ALU x5 then consumer of rs1=x5 next cycle → `fwd_rs1_o`=1, `stall_o`=0. Same consumer two cycles later → `fwd_rs1_o`=2.
- LOAD x7 then consumer of rs2=x7 (`LOAD_LAT`=1) → 1 cycle `stall_o`=1/`bubble_o`=1 with `fwd_rs2_o`=0, then `fwd_rs2_o`=2. `stall_cnt_o` increments by 1.
- JAL with rd=x1 then JALR with rs1=x1 → `fwd_rs1_o`=1, `link_rs1_o`=1. Writes to x0 and reads of x0 always give sel 0.
- Two writers of x3 in stages 1 and 2 → youngest wins, `fwd`=1. Consumer with rs2_used=0 and rs2=x3 → `fwd_rs2_o`=0.
- `mem_busy_i` high for 3 cycles during a load hazard → shadow state unchanged, `bubble_o`=0, `stall_cnt_o` unchanged; the hazard resolves after release.
- `flush_i` together with a hazard, and `rst_i` mid-stall → entry 1 invalid, `flush_cnt_o`+1; after reset, all outputs 0 and counters 0.
